// File: rtl/cpu_sram_arbiter.sv
// Two-port sram-like bus arbiter: inst fetch and data ports share one bus, with in-order data return routing.
// Optional ARB_RR_EN selects round-robin priority instead of fixed data-over-inst.
module cpu_sram_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  typedef enum logic {S_IDLE, S_ADDR} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_grant;
  logic               r_wr;
  logic [1:0]         r_size;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_fifo [MAX_OUTSTANDING];

  logic               w_full;
  logic               w_empty;
  logic               w_win;
  logic               w_load;
  logic               w_push;
  logic               w_pop;
  logic               w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rptr];
  assign w_pop   = data_ok && !w_empty;

`ifdef ARB_RR_EN
  // Set means data wins the next tie; flips toward the port not served last.
  logic r_prio_data;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_prio_data <= 1'b1;
    end else if (w_push) begin
      r_prio_data <= (r_grant == ID_INST);
    end
  end

  always_comb begin
    w_win = ID_INST;
    if (inst_req && data_req) begin
      w_win = r_prio_data ? ID_DATA : ID_INST;
    end else if (data_req) begin
      w_win = ID_DATA;
    end
  end
`else
  always_comb begin
    w_win = ID_INST;
    if (data_req) begin
      w_win = ID_DATA;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant only from IDLE with FIFO space; ADDR holds until the bus accepts.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_full && (inst_req || data_req)) begin
          w_load      = 1'b1;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (addr_ok) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_grant <= ID_INST;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_load) begin
      r_grant <= w_win;
      r_wr    <= (w_win == ID_DATA) ? data_wr    : inst_wr;
      r_size  <= (w_win == ID_DATA) ? data_size  : inst_size;
      r_addr  <= (w_win == ID_DATA) ? data_addr  : inst_addr;
      r_wdata <= (w_win == ID_DATA) ? data_wdata : inst_wdata;
    end
  end

  // In-order source-ID FIFO; a same-cycle pop reads the old head.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        r_fifo[i] <= ID_INST;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= r_grant;
        r_wptr         <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign req   = (r_state == S_ADDR);
  assign wr    = r_wr;
  assign size  = r_size;
  assign addr  = r_addr;
  assign wdata = r_wdata;

  assign inst_addr_ok = w_push && (r_grant == ID_INST);
  assign data_addr_ok = w_push && (r_grant == ID_DATA);
  assign inst_data_ok = w_pop  && (w_head  == ID_INST);
  assign data_data_ok = w_pop  && (w_head  == ID_DATA);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed self-checking bench for cpu_sram_arbiter (default MAX_OUTSTANDING=2).
module tb_cpu_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  int n_vec = 0;
  int n_err = 0;

  cpu_sram_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'hffff_ffff; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd0; data_addr = 0; data_wdata = 0;
    addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h1234_5678;
    step(); step();
    #3;
    if (req !== 1'b0)     begin $display("FAIL reset_req got %b exp 0", req); n_err++; end
    n_vec++;
    if ({wr, size, addr, wdata} !== 67'd0) begin
      $display("FAIL reset_bus got wr=%b size=%0d addr=%h wdata=%h exp all 0", wr, size, addr, wdata); n_err++;
    end
    n_vec++;
    if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0000) begin
      $display("FAIL reset_pulses got %b exp 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); n_err++;
    end
    n_vec++;
    addr_ok = 0; data_ok = 0;
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    inst_req = 1; inst_addr = 32'hbfc0_0000; inst_size = 2'd2;
    #3;
    if (req !== 1'b0) begin $display("FAIL fetch_req_n got %b exp 0", req); n_err++; end
    n_vec++;
    step();
    if (req !== 1'b1 || addr !== 32'hbfc0_0000 || size !== 2'd2) begin
      $display("FAIL fetch_bus got req=%b addr=%h size=%0d exp 1 bfc00000 2", req, addr, size); n_err++;
    end
    n_vec++;
    addr_ok = 1;
    #3;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      $display("FAIL fetch_addr_ok got %b exp 10", {inst_addr_ok, data_addr_ok}); n_err++;
    end
    n_vec++;
    step();
    inst_req = 0; addr_ok = 0;
    #3;
    if (req !== 1'b0) begin $display("FAIL fetch_req_drop got %b exp 0", req); n_err++; end
    n_vec++;
    step();
    data_ok = 1; rdata = 32'h3c08_0001;
    #3;
    if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h3c08_0001) begin
      $display("FAIL fetch_data_ok got ok=%b rdata=%h exp 10 3c080001", {inst_data_ok, data_data_ok}, inst_rdata); n_err++;
    end
    n_vec++;
    step();
    data_ok = 0;
    step();
  endtask

  task automatic test_contention();
    logic [31:0] exp_addr2;
    logic [1:0]  exp_ok2;
`ifdef ARB_RR_EN
    exp_addr2 = 32'hbfc0_0004; exp_ok2 = 2'b10;
`else
    exp_addr2 = 32'h8000_1004; exp_ok2 = 2'b01;
`endif
    inst_req = 1; inst_addr = 32'hbfc0_0004;
    data_req = 1; data_addr = 32'h8000_1000; data_wr = 1; data_wdata = 32'ha5a5_a5a5; data_size = 2'd2;
    step();
    if (req !== 1'b1 || addr !== 32'h8000_1000 || wr !== 1'b1 || wdata !== 32'ha5a5_a5a5) begin
      $display("FAIL cont_first got addr=%h wr=%b wdata=%h exp 80001000 1 a5a5a5a5", addr, wr, wdata); n_err++;
    end
    n_vec++;
    addr_ok = 1;
    #3;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
      $display("FAIL cont_first_ok got %b exp 01", {inst_addr_ok, data_addr_ok}); n_err++;
    end
    n_vec++;
    step();
    addr_ok = 0; data_addr = 32'h8000_1004; data_wr = 0;
    step();
    if (req !== 1'b1 || addr !== exp_addr2) begin
      $display("FAIL cont_second got req=%b addr=%h exp 1 %h", req, addr, exp_addr2); n_err++;
    end
    n_vec++;
    addr_ok = 1;
    #3;
    if ({inst_addr_ok, data_addr_ok} !== exp_ok2) begin
      $display("FAIL cont_second_ok got %b exp %b", {inst_addr_ok, data_addr_ok}, exp_ok2); n_err++;
    end
    n_vec++;
    step();
    addr_ok = 0; inst_req = 0; data_req = 0;
    step();
    data_ok = 1;
    #3;
    if ({inst_data_ok, data_data_ok} !== 2'b01) begin
      $display("FAIL cont_ret1 got %b exp 01", {inst_data_ok, data_data_ok}); n_err++;
    end
    n_vec++;
    step();
    #3;
    if ({inst_data_ok, data_data_ok} !== exp_ok2) begin
      $display("FAIL cont_ret2 got %b exp %b", {inst_data_ok, data_data_ok}, exp_ok2); n_err++;
    end
    n_vec++;
    step();
    data_ok = 0;
    step();
  endtask

  task automatic test_return_order();
    data_req = 1; data_addr = 32'h8000_2000;
    step();
    addr_ok = 1;
    step();
    addr_ok = 0; data_req = 0; inst_req = 1; inst_addr = 32'hbfc0_0008;
    step();
    if (addr !== 32'hbfc0_0008) begin $display("FAIL order_inst_addr got %h exp bfc00008", addr); n_err++; end
    n_vec++;
    addr_ok = 1;
    step();
    addr_ok = 0; inst_req = 0;
    data_ok = 1; rdata = 32'h1111_1111;
    #3;
    if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'h1111_1111) begin
      $display("FAIL order_ret1 got %b %h exp 01 11111111", {inst_data_ok, data_data_ok}, data_rdata); n_err++;
    end
    n_vec++;
    step();
    rdata = 32'h2222_2222;
    #3;
    if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h2222_2222) begin
      $display("FAIL order_ret2 got %b %h exp 10 22222222", {inst_data_ok, data_data_ok}, inst_rdata); n_err++;
    end
    n_vec++;
    step();
    data_ok = 0;
    step();
  endtask

  task automatic test_simultaneous();
    // One inst outstanding; data address accept coincides with the inst data return.
    inst_req = 1; inst_addr = 32'hbfc0_000c;
    step();
    addr_ok = 1;
    step();
    addr_ok = 0; inst_req = 0; data_req = 1; data_addr = 32'h8000_3000;
    step();
    addr_ok = 1; data_ok = 1;
    #3;
    if ({data_addr_ok, inst_data_ok, data_data_ok} !== 3'b110) begin
      $display("FAIL simul_push_pop got %b exp 110", {data_addr_ok, inst_data_ok, data_data_ok}); n_err++;
    end
    n_vec++;
    step();
    addr_ok = 0; data_req = 0; data_ok = 1;
    #3;
    if ({inst_data_ok, data_data_ok} !== 2'b01) begin
      $display("FAIL simul_ret got %b exp 01", {inst_data_ok, data_data_ok}); n_err++;
    end
    n_vec++;
    step();
    data_ok = 0;
    #3;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      $display("FAIL simul_empty got %b exp 00", {inst_data_ok, data_data_ok}); n_err++;
    end
    n_vec++;
    step();
  endtask

  task automatic test_fifo_full();
    inst_req = 1; inst_addr = 32'hbfc0_0010;
    step();
    addr_ok = 1;
    step();
    addr_ok = 0;
    step();
    addr_ok = 1;
    step();
    addr_ok = 0;
    #3;
    if (req !== 1'b0) begin $display("FAIL full_req0 got %b exp 0", req); n_err++; end
    n_vec++;
    step();
    if (req !== 1'b0) begin $display("FAIL full_req1 got %b exp 0", req); n_err++; end
    n_vec++;
    data_ok = 1;
    #3;
    if (inst_data_ok !== 1'b1) begin $display("FAIL full_pop got %b exp 1", inst_data_ok); n_err++; end
    n_vec++;
    step();
    data_ok = 0;
    #3;
    if (req !== 1'b0) begin $display("FAIL full_grant_cycle got %b exp 0", req); n_err++; end
    n_vec++;
    step();
    if (req !== 1'b1) begin $display("FAIL full_regrant got %b exp 1", req); n_err++; end
    n_vec++;
    addr_ok = 1;
    step();
    addr_ok = 0; inst_req = 0; data_ok = 1;
    step();
    step();
    data_ok = 0;
    step();
  endtask

  task automatic test_spurious();
    data_ok = 1;
    #3;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      $display("FAIL spur_ignored got %b exp 00", {inst_data_ok, data_data_ok}); n_err++;
    end
    n_vec++;
    step();
    data_ok = 0; data_req = 1; data_addr = 32'h8000_4000;
    step();
    addr_ok = 1;
    step();
    addr_ok = 0; data_req = 0; data_ok = 1;
    #3;
    if ({inst_data_ok, data_data_ok} !== 2'b01) begin
      $display("FAIL spur_follow got %b exp 01", {inst_data_ok, data_data_ok}); n_err++;
    end
    n_vec++;
    step();
    data_ok = 0;
    step();
  endtask

  task automatic test_reset_mid();
    data_req = 1; data_addr = 32'h8000_5000;
    step();
    addr_ok = 1;
    step();
    addr_ok = 0; data_req = 0; inst_req = 1; inst_addr = 32'hbfc0_0020;
    step();
    if (req !== 1'b1) begin $display("FAIL rmid_req got %b exp 1", req); n_err++; end
    n_vec++;
    resetn = 0; inst_req = 0;
    step();
    data_ok = 1;
    #3;
    if (req !== 1'b0 || {inst_data_ok, data_data_ok} !== 2'b00) begin
      $display("FAIL rmid_after got req=%b ok=%b exp 0 00", req, {inst_data_ok, data_data_ok}); n_err++;
    end
    n_vec++;
    step();
    resetn = 1;
    #3;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      $display("FAIL rmid_late got %b exp 00", {inst_data_ok, data_data_ok}); n_err++;
    end
    n_vec++;
    step();
    data_ok = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_return_order();
    test_simultaneous();
    test_fifo_full();
    test_spurious();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
